// File: rtl/sisc_pkg.sv
// Shared SISC definitions: instruction-memory geometry and loader FSM encodings.
// Optional feature macro: CHECKSUM_EN (loader accepts and checks a trailing XOR byte).
package sisc_pkg;

  localparam int unsigned IM_ADDR_W = 16;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_HDR_HI = 3'd1,
    LD_HDR_LO = 3'd2,
    LD_WORD   = 3'd3,
    LD_TAIL   = 3'd4,
    LD_DONE   = 3'd5,
    LD_ERR    = 3'd6
  } ld_state_e;

  // States in which the loader takes a byte from the stream.
  function automatic logic ld_accepts(input ld_state_e s);
`ifdef CHECKSUM_EN
    return (s == LD_HDR_HI) || (s == LD_HDR_LO) || (s == LD_WORD) || (s == LD_TAIL);
`else
    return (s == LD_HDR_HI) || (s == LD_HDR_LO) || (s == LD_WORD);
`endif
  endfunction

endpackage

// File: rtl/im_byte_asm.sv
// Big-endian byte-to-word assembler for the IM loader.
// Ports:
//   clk, rst_f      clock, synchronous active-high reset
//   clr             drop any partial word
//   accept          a stream byte transfers this cycle
//   byte_in         the stream byte
//   word_rdy_c      4th byte of a word transfers this cycle (combinational)
//   word_c          completed word, first byte in [31:24] (combinational)
module im_byte_asm
  import sisc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_f,
  input  logic               clr,
  input  logic               accept,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic               word_rdy_c,
  output logic [INSTR_W-1:0] word_c
);

  localparam int unsigned SH_W = INSTR_W - BYTE_W;

  logic [1:0]      cnt_q, cnt_d;
  logic [SH_W-1:0] sh_q, sh_d;

  // Byte counter and shift register; only the first three bytes need storage.
  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr) begin
      cnt_d = 2'd0;
    end else if (accept) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = {sh_q[SH_W-BYTE_W-1:0], byte_in};
    end
  end

  assign word_rdy_c = accept && !clr && (cnt_q == 2'd3);
  assign word_c     = {sh_q, byte_in};

  always_ff @(posedge clk) begin
    if (rst_f) begin
      cnt_q <= 2'd0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Streams a counted, big-endian word image into the SISC instruction memory and
// holds the CPU in reset until the image is complete.
// Optional feature macro: CHECKSUM_EN (one trailing XOR byte over header + data).
// Ports:
//   clk, rst_f          clock, synchronous active-high reset
//   start               begin a load (honoured in IDLE, DONE, ERR)
//   in_data/in_valid    byte stream; in_ready is the loader's side of the handshake
//   im_we/addr/wdata    registered instruction-memory write port
//   cpu_hold            1 holds the processor in reset
//   done, err           load outcome levels
module im_loader
  import sisc_pkg::*;
#(
  parameter logic [IM_ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter int unsigned          MAX_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 rst_f,
  input  logic                 start,
  input  logic [BYTE_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [INSTR_W-1:0]   im_wdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err
);

  ld_state_e            state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     word_idx_q, word_idx_d;
  logic                 in_ready_q, in_ready_d;
  logic                 im_we_q, im_we_d;
  logic [IM_ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [INSTR_W-1:0]   im_wdata_q, im_wdata_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
`ifdef CHECKSUM_EN
  logic [BYTE_W-1:0]    csum_q, csum_d;
`endif

  logic                 hs_c;
  logic                 restart_c;
  logic                 word_rdy_c;
  logic [INSTR_W-1:0]   word_c;
  logic [CNT_W-1:0]     hdr_cnt_c;

  // in_ready_q mirrors the current state, so it alone qualifies the handshake.
  assign hs_c      = in_valid && in_ready_q;
  assign restart_c = start && ((state_q == LD_IDLE) || (state_q == LD_DONE) || (state_q == LD_ERR));
  assign hdr_cnt_c = {count_q[CNT_W-1:BYTE_W], in_data};

  im_byte_asm u_asm (
    .clk        (clk),
    .rst_f      (rst_f),
    .clr        (restart_c),
    .accept     (hs_c && (state_q == LD_WORD)),
    .byte_in    (in_data),
    .word_rdy_c (word_rdy_c),
    .word_c     (word_c)
  );

  // Next-state, counters and registered output values.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
`ifdef CHECKSUM_EN
    csum_d     = csum_q;
    if (hs_c && (state_q != LD_TAIL)) begin
      csum_d = csum_q ^ in_data;
    end
`endif

    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_d    = LD_HDR_HI;
          word_idx_d = '0;
          im_addr_d  = BASE_ADDR;
`ifdef CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      LD_HDR_HI: begin
        if (hs_c) begin
          count_d = {in_data, count_q[BYTE_W-1:0]};
          state_d = LD_HDR_LO;
        end
      end
      LD_HDR_LO: begin
        if (hs_c) begin
          count_d = hdr_cnt_c;
          if (32'(hdr_cnt_c) > MAX_WORDS) begin
            state_d = LD_ERR;
          end else if (hdr_cnt_c == '0) begin
            state_d = LD_TAIL;
          end else begin
            state_d = LD_WORD;
          end
        end
      end
      LD_WORD: begin
        if (word_rdy_c) begin
          im_we_d    = 1'b1;
          im_addr_d  = BASE_ADDR + word_idx_q;
          im_wdata_d = word_c;
          word_idx_d = word_idx_q + 16'd1;
          if (word_idx_q == count_q - 16'd1) begin
            state_d = LD_TAIL;
          end
        end
      end
      LD_TAIL: begin
`ifdef CHECKSUM_EN
        if (hs_c) begin
          state_d = (in_data == csum_q) ? LD_DONE : LD_ERR;
        end
`else
        state_d = LD_DONE;
`endif
      end
      default: state_d = LD_IDLE;
    endcase

    in_ready_d = ld_accepts(state_d);
    cpu_hold_d = (state_d != LD_DONE);
    done_d     = (state_d == LD_DONE);
    err_d      = (state_d == LD_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q    <= LD_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE_ADDR;
      im_wdata_q <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: two instances share one stream, one at base 0000
// and one at base FFFF, and every write of each is logged for comparison.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_f, start, in_valid;
  logic [7:0]  in_data;

  logic        a_in_ready, a_im_we, a_cpu_hold, a_done, a_err;
  logic [15:0] a_im_addr;
  logic [31:0] a_im_wdata;
  logic        b_in_ready, b_im_we, b_cpu_hold, b_done, b_err;
  logic [15:0] b_im_addr;
  logic [31:0] b_im_wdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  tb_xor;
  logic [47:0] wq_a[$];
  logic [47:0] wq_b[$];

  always #5 clk = ~clk;

  im_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(1024)) dut_a (
    .clk(clk), .rst_f(rst_f), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .im_we(a_im_we), .im_addr(a_im_addr), .im_wdata(a_im_wdata),
    .cpu_hold(a_cpu_hold), .done(a_done), .err(a_err)
  );

  im_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(1024)) dut_b (
    .clk(clk), .rst_f(rst_f), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .im_we(b_im_we), .im_addr(b_im_addr), .im_wdata(b_im_wdata),
    .cpu_hold(b_cpu_hold), .done(b_done), .err(b_err)
  );

  // Write logger.
  always @(negedge clk) begin
    if (a_im_we) wq_a.push_back({a_im_addr, a_im_wdata});
    if (b_im_we) wq_b.push_back({b_im_addr, b_im_wdata});
  end

  task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start  = 1'b1;
    tb_xor = 8'h00;
    tick();
    start  = 1'b0;
  endtask

  // Offers a byte after 'gap' idle cycles; returns #1 after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    tb_xor   = tb_xor ^ b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("hs_timeout", 48'd0, 48'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    send_byte(w[31:24], $urandom_range(0, maxgap));
    send_byte(w[23:16], $urandom_range(0, maxgap));
    send_byte(w[15:8],  $urandom_range(0, maxgap));
    send_byte(w[7:0],   $urandom_range(0, maxgap));
  endtask

  task automatic send_tail();
`ifdef CHECKSUM_EN
    logic [7:0] c;
    c = tb_xor;
    send_byte(c, 0);
`endif
  endtask

  initial begin
    rst_f = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; tb_xor = 8'h00;
    tick(); tick();
    check("rst_in_ready", 48'(a_in_ready), 48'd0);
    check("rst_im_we",    48'(a_im_we),    48'd0);
    check("rst_addr_a",   48'(a_im_addr),  48'h0000);
    check("rst_addr_b",   48'(b_im_addr),  48'hFFFF);
    check("rst_wdata",    48'(a_im_wdata), 48'd0);
    check("rst_hold",     48'(a_cpu_hold), 48'd1);
    check("rst_done_err", 48'({a_done, a_err}), 48'd0);
    rst_f = 1'b0;
    tick();

    // 1: two words back to back
    pulse_start();
    check("t1_ready", 48'(a_in_ready), 48'd1);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(32'h12345678, 0);
    check("t1_hold_busy", 48'(a_cpu_hold), 48'd1);
    send_word(32'h9ABCDEF0, 0);
    check("t1_we_last", 48'({a_im_we, a_im_addr, a_im_wdata}) , 48'({1'b1, 16'h0001, 32'h9ABCDEF0}));
    send_tail();
    tick(); tick();
    check("t1_done",  48'({a_done, a_err, a_cpu_hold, a_in_ready}), 48'b1000);
    check("t1_nwr",   48'(wq_a.size()), 48'd2);
    check("t1_wr0",   wq_a[0], {16'h0000, 32'h12345678});
    check("t1_wr1",   wq_a[1], {16'h0001, 32'h9ABCDEF0});

    // 2: empty image
    wq_a.delete(); wq_b.delete();
    pulse_start();
    check("t2_restart", 48'({a_done, a_cpu_hold}), 48'b01);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef CHECKSUM_EN
    send_tail();
    tick();
`else
    check("t2_done_early", 48'(a_done), 48'd0);
    tick();
`endif
    check("t2_done",  48'({a_done, a_cpu_hold}), 48'b10);
    tick(); tick();
    check("t2_nwr",   48'(wq_a.size()), 48'd0);

    // 3: count 0x0401 exceeds MAX_WORDS
    pulse_start();
    send_byte(8'h04, 0); send_byte(8'h01, 0);
    check("t3_err",   48'({a_err, a_done, a_cpu_hold, a_in_ready}), 48'b1010);
    tick(); tick();
    check("t3_nwr",   48'(wq_a.size()), 48'd0);

    // 4: reset after two data bytes, with a coincident start
    pulse_start();
    check("t4_clr_err", 48'(a_err), 48'd0);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    rst_f = 1'b1; start = 1'b1;
    tick();
    rst_f = 1'b0; start = 1'b0;
    check("t4_idle",  48'({a_cpu_hold, a_in_ready, a_im_we}), 48'b100);
    check("t4_addr",  48'(a_im_addr), 48'h0000);
    tick(); tick();
    check("t4_nwr",   48'(wq_a.size()), 48'd0);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'hAABBCCDD, 0);
    send_tail();
    tick(); tick();
    check("t4_nwr2",  48'(wq_a.size()), 48'd1);
    check("t4_wr0",   wq_a[0], {16'h0000, 32'hAABBCCDD});
    check("t4_done",  48'(a_done), 48'd1);

    // 5: random gaps, address wrap on the FFFF-based instance
    wq_a.delete(); wq_b.delete();
    pulse_start();
    send_byte(8'h00, 2); send_byte(8'h02, 3);
    send_word(32'h13579BDF, 3);
    send_word(32'h2468ACE0, 3);
    send_tail();
    tick(); tick();
    check("t5_nwr_b", 48'(wq_b.size()), 48'd2);
    check("t5_b0",    wq_b[0], {16'hFFFF, 32'h13579BDF});
    check("t5_b1",    wq_b[1], {16'h0000, 32'h2468ACE0});
    check("t5_nwr_a", 48'(wq_a.size()), 48'd2);
    check("t5_a1",    wq_a[1], {16'h0001, 32'h2468ACE0});
    check("t5_done",  48'({b_done, b_cpu_hold}), 48'b10);

`ifdef CHECKSUM_EN
    // 6: checksum good then bad
    wq_a.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'h11223344, 0);
    send_byte(8'h45, 0);
    tick();
    check("t6_good",  48'({a_done, a_err, a_cpu_hold}), 48'b100);
    wq_a.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(32'h11223344, 0);
    send_byte(8'h46, 0);
    tick();
    check("t6_bad",   48'({a_done, a_err, a_cpu_hold}), 48'b011);
    check("t6_nwr",   48'(wq_a.size()), 48'd1);
    check("t6_wr0",   wq_a[0], {16'h0000, 32'h11223344});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
